// File: rtl/pdm_sample_sched.sv
// +--------------------------------------------------------------------------+
// | pdm_sample_sched: sample FIFO, tick scheduler and soft-start ramp for    |
// | the PDM modulator. Optional macro PDM_SCHED_HOLD_EN holds on underrun.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pdm_sample_sched #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int TICK_DIV  = 2048,
  parameter int RAMP_STEP = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [WIDTH-1:0]         sample_in,
  input  logic                     sample_valid_in,
  output logic                     sample_ready_out,
  input  logic                     enable_in,
  input  logic                     mute_in,
  output logic [WIDTH-1:0]         level_out,
  output logic                     tick_out,
  output logic                     underrun_out,
  output logic [$clog2(DEPTH):0]   fill_out,
  output logic [1:0]               state_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0]    TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MID       = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   STEP      = (WIDTH+1)'(RAMP_STEP);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(DEPTH);
`ifdef PDM_SCHED_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_RUN       = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] level_q;
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             tick;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             flush;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] conv;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] up_lvl_d;
  logic [WIDTH-1:0] dn_lvl_d;
  logic [WIDTH-1:0] run_lvl_d;

  assign tick  = (cnt_q == TICK_LAST);
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign sample_ready_out = !full && (state_q == S_RAMP_UP || state_q == S_RUN);
  assign push  = sample_valid_in && sample_ready_out;
  assign pop   = tick && (state_q == S_RUN) && !empty;

  assign head  = mem_q[rd_q];
  assign conv  = {~head[WIDTH-1], head[WIDTH-2:0]};

  // Ramp arithmetic is one bit wider so the clamp sees any carry.
  assign up_sum    = {1'b0, level_q} + STEP;
  assign up_lvl_d  = (up_sum >= {1'b0, MID}) ? MID : up_sum[WIDTH-1:0];
  assign dn_lvl_d  = ({1'b0, level_q} > STEP) ? (level_q - STEP[WIDTH-1:0]) : '0;
  assign run_lvl_d = !empty ? (mute_in ? MID : conv) : (HOLD ? level_q : MID);

  assign flush = tick && (state_q == S_RAMP_DOWN) && (dn_lvl_d == '0);

  assign level_out    = level_q;
  assign tick_out     = tick;
  assign underrun_out = tick && (state_q == S_RUN) && empty;
  assign fill_out     = count_q;
  assign state_out    = state_q;

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_q] <= sample_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;

      if (flush) begin
        wr_q    <= '0;
        rd_q    <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (!push && pop) count_q <= count_q - 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          level_q <= '0;
          if (enable_in) state_q <= S_RAMP_UP;
        end
        S_RAMP_UP: begin
          if (tick) level_q <= up_lvl_d;
          if (!enable_in)                   state_q <= S_RAMP_DOWN;
          else if (tick && up_lvl_d == MID) state_q <= S_RUN;
        end
        S_RUN: begin
          if (tick)       level_q <= run_lvl_d;
          if (!enable_in) state_q <= S_RAMP_DOWN;
        end
        S_RAMP_DOWN: begin
          if (tick) begin
            level_q <= dn_lvl_d;
            if (dn_lvl_d == '0) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
